// File: rtl/wb_stage_nway.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : wb_stage_nway                                              |
// | Description : Registered N-lane write-back stage. Holds one MEM->WB      |
// |               packet, gates GPR/CSR writes behind the oldest faulting    |
// |               lane, raises exception/ertn flush pulses and counts        |
// |               retired instructions.                                      |
// | Option      : WB_SOFT_INT_EN adds the soft_int input, which raises an    |
// |               interrupt on the oldest valid lane of the held packet.     |
// | Revision    : 1.0 - initial N-lane release                               |
// +--------------------------------------------------------------------------+
module wb_stage_nway #(
  parameter int NUM_LANES = 2,
  parameter int DATA_W    = 32,
  parameter int RIDX_W    = 5,
  parameter int CSR_W     = 47
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  left_valid,
  output logic                                  left_ready,
  input  logic [NUM_LANES-1:0]                  in_lane_v,
  input  logic [NUM_LANES*DATA_W-1:0]           in_result,
  input  logic [NUM_LANES*DATA_W-1:0]           in_pc,
  input  logic [NUM_LANES*DATA_W-1:0]           in_inst,
  input  logic [NUM_LANES-1:0]                  in_wen,
  input  logic [NUM_LANES*RIDX_W-1:0]           in_widx,
  input  logic [NUM_LANES*9-1:0]                in_excp,
  input  logic [NUM_LANES-1:0]                  in_ertn,
  input  logic [NUM_LANES*CSR_W-1:0]            in_csr,
  input  logic                                  right_ready,
`ifdef WB_SOFT_INT_EN
  input  logic                                  soft_int,
`endif
  output logic                                  right_valid,
  output logic [NUM_LANES-1:0]                  rf_we,
  output logic [NUM_LANES*RIDX_W-1:0]           rf_waddr,
  output logic [NUM_LANES*DATA_W-1:0]           rf_wdata,
  output logic [NUM_LANES*CSR_W-1:0]            csr_bus,
  output logic [NUM_LANES*(DATA_W+RIDX_W+1)-1:0] bypass,
  output logic                                  excp_flush,
  output logic                                  ertn_flush,
  output logic [DATA_W-1:0]                     excp_era,
  output logic [5:0]                            ecode,
  output logic [8:0]                            esubcode,
  output logic [DATA_W-1:0]                     badv,
  output logic                                  badv_valid,
  output logic [63:0]                           retired
);

  localparam int       BYP_W      = DATA_W + RIDX_W + 1;
  localparam int       LIDX_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam logic [5:0] ECODE_INT = 6'h00;
  localparam logic [5:0] ECODE_ADE = 6'h08;
  localparam logic [5:0] ECODE_SYS = 6'h0B;
  localparam logic [5:0] ECODE_BRK = 6'h0C;
  localparam logic [5:0] ECODE_INE = 6'h0D;
  localparam logic [5:0] ECODE_IPE = 6'h0E;

  logic                                valid_q,  valid_d;
  logic [NUM_LANES-1:0]                lane_v_q, lane_v_d;
  logic [NUM_LANES-1:0][DATA_W-1:0]    result_q, result_d;
  logic [NUM_LANES-1:0][DATA_W-1:0]    pc_q,     pc_d;
  logic [NUM_LANES-1:0]                wen_q,    wen_d;
  logic [NUM_LANES-1:0][RIDX_W-1:0]    widx_q,   widx_d;
  logic [NUM_LANES-1:0][8:0]           excp_q,   excp_d;
  logic [NUM_LANES-1:0]                ertn_q,   ertn_d;
  logic [NUM_LANES-1:0][CSR_W-1:0]     csr_q,    csr_d;
  logic [63:0]                         retired_q, retired_d;

  logic [NUM_LANES-1:0][8:0]           excp_eff;
  logic [NUM_LANES-1:0]                squash;
  logic [NUM_LANES-1:0]                commit;
  logic                                fault_found;
  logic [LIDX_W-1:0]                   fault_idx;
  logic [8:0]                          fault_excp;
  logic [DATA_W-1:0]                   fault_pc;
  logic                                flush;
  logic                                accept;
  logic                                drain;
  logic [2:0]                          commit_cnt;

  // The instruction word has no consumer at this stage; it stays on the port for trace hookup.
  logic unused_inst;
  assign unused_inst = ^in_inst;

  // Locate the oldest lane carrying an exception or ertn; it and every younger lane are squashed.
  always_comb begin
    excp_eff    = excp_q;
`ifdef WB_SOFT_INT_EN
    begin : soft_int_inject
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < NUM_LANES; i++) begin
        if (!seen && lane_v_q[i]) begin
          excp_eff[i][0] = excp_q[i][0] | (soft_int & valid_q);
          seen = 1'b1;
        end
      end
    end
`endif
    fault_found = 1'b0;
    fault_idx   = '0;
    squash      = '0;
    commit      = '0;
    commit_cnt  = 3'd0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (!fault_found && valid_q && lane_v_q[i] && ((|excp_eff[i]) || ertn_q[i])) begin
        fault_found = 1'b1;
        fault_idx   = LIDX_W'(i);
      end
      squash[i]  = fault_found;
      commit[i]  = valid_q & lane_v_q[i] & ~squash[i];
      commit_cnt = commit_cnt + {2'b00, commit[i]};
    end
    fault_excp = excp_eff[fault_idx];
    fault_pc   = pc_q[fault_idx];
    excp_flush = fault_found & (|fault_excp);
    ertn_flush = fault_found & ertn_q[fault_idx] & ~(|fault_excp);
    // An ertn retires itself; an excepting instruction does not.
    commit_cnt = commit_cnt + {2'b00, ertn_flush};
  end

  // Exception cause decode for the faulting lane, fixed priority int > adef > sys > brk > ine > ipe.
  always_comb begin
    ecode      = 6'h00;
    esubcode   = 9'h000;
    excp_era   = '0;
    badv       = '0;
    badv_valid = 1'b0;
    if (excp_flush) begin
      excp_era = fault_pc;
      if (fault_excp[0]) begin
        ecode = ECODE_INT;
      end else if (fault_excp[1]) begin
        ecode      = ECODE_ADE;
        badv       = fault_pc;
        badv_valid = 1'b1;
      end else if (fault_excp[5]) begin
        ecode = ECODE_SYS;
      end else if (fault_excp[6]) begin
        ecode = ECODE_BRK;
      end else if (fault_excp[7]) begin
        ecode = ECODE_INE;
      end else if (fault_excp[8]) begin
        ecode = ECODE_IPE;
      end
    end
  end

  // Per-lane commit outputs: writes and CSR enables are masked by the squash vector.
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      rf_we[i]                        = commit[i] & wen_q[i];
      rf_waddr[i*RIDX_W +: RIDX_W]    = widx_q[i];
      rf_wdata[i*DATA_W +: DATA_W]    = result_q[i];
      csr_bus[i*CSR_W +: CSR_W]       = {csr_q[i][CSR_W-1] & commit[i], csr_q[i][CSR_W-2:0]};
      bypass[i*BYP_W +: BYP_W]        = {result_q[i], widx_q[i], commit[i] & wen_q[i]};
    end
  end

  // Slot control: a flush empties the slot regardless of downstream and drops any same-cycle accept.
  always_comb begin
    flush       = excp_flush | ertn_flush;
    left_ready  = ~valid_q | right_ready;
    right_valid = valid_q;
    retired     = retired_q;
    accept      = left_valid & left_ready & ~flush;
    drain       = valid_q & (right_ready | flush);

    if (flush)                   valid_d = 1'b0;
    else if (accept)             valid_d = 1'b1;
    else if (valid_q & right_ready) valid_d = 1'b0;
    else                         valid_d = valid_q;

    lane_v_d  = accept ? in_lane_v : lane_v_q;
    result_d  = accept ? in_result : result_q;
    pc_d      = accept ? in_pc     : pc_q;
    wen_d     = accept ? in_wen    : wen_q;
    widx_d    = accept ? in_widx   : widx_q;
    excp_d    = accept ? in_excp   : excp_q;
    ertn_d    = accept ? in_ertn   : ertn_q;
    csr_d     = accept ? in_csr    : csr_q;
    retired_d = drain ? (retired_q + 64'(commit_cnt)) : retired_q;
  end

  // State registers with synchronous reset; a reset discards any held packet.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b0;
      lane_v_q  <= '0;
      result_q  <= '0;
      pc_q      <= '0;
      wen_q     <= '0;
      widx_q    <= '0;
      excp_q    <= '0;
      ertn_q    <= '0;
      csr_q     <= '0;
      retired_q <= '0;
    end else begin
      valid_q   <= valid_d;
      lane_v_q  <= lane_v_d;
      result_q  <= result_d;
      pc_q      <= pc_d;
      wen_q     <= wen_d;
      widx_q    <= widx_d;
      excp_q    <= excp_d;
      ertn_q    <= ertn_d;
      csr_q     <= csr_d;
      retired_q <= retired_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_stage_nway.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_wb_stage_nway                                           |
// | Description : Self-checking bench for wb_stage_nway (2 lanes), directed  |
// |               scenarios followed by random traffic against a reference   |
// |               model of the write-back slot. Honours WB_SOFT_INT_EN.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_wb_stage_nway;

  localparam int N  = 2;
  localparam int DW = 32;
  localparam int RW = 5;
  localparam int CW = 47;
  localparam int BW = DW + RW + 1;

  logic clk = 1'b0;
  logic reset;
  logic left_valid, left_ready, right_ready, right_valid;
  logic [N-1:0]      in_lane_v, in_wen, in_ertn, rf_we;
  logic [N*DW-1:0]   in_result, in_pc, in_inst, rf_wdata;
  logic [N*RW-1:0]   in_widx, rf_waddr;
  logic [N*9-1:0]    in_excp;
  logic [N*CW-1:0]   in_csr, csr_bus;
  logic [N*BW-1:0]   bypass;
  logic              excp_flush, ertn_flush, badv_valid;
  logic [DW-1:0]     excp_era, badv;
  logic [5:0]        ecode;
  logic [8:0]        esubcode;
  logic [63:0]       retired;
`ifdef WB_SOFT_INT_EN
  logic              soft_int = 1'b0;
`endif

  always #5 clk = ~clk;

  wb_stage_nway #(.NUM_LANES(N), .DATA_W(DW), .RIDX_W(RW), .CSR_W(CW)) dut (
    .clk(clk), .reset(reset), .left_valid(left_valid), .left_ready(left_ready),
    .in_lane_v(in_lane_v), .in_result(in_result), .in_pc(in_pc), .in_inst(in_inst),
    .in_wen(in_wen), .in_widx(in_widx), .in_excp(in_excp), .in_ertn(in_ertn),
    .in_csr(in_csr), .right_ready(right_ready),
`ifdef WB_SOFT_INT_EN
    .soft_int(soft_int),
`endif
    .right_valid(right_valid), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .csr_bus(csr_bus), .bypass(bypass), .excp_flush(excp_flush), .ertn_flush(ertn_flush),
    .excp_era(excp_era), .ecode(ecode), .esubcode(esubcode), .badv(badv),
    .badv_valid(badv_valid), .retired(retired)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model of the held packet.
  bit          m_valid;
  bit          m_lv   [N];
  logic [DW-1:0] m_res [N];
  logic [DW-1:0] m_pc  [N];
  bit          m_wen  [N];
  logic [RW-1:0] m_widx [N];
  logic [8:0]  m_excp [N];
  bit          m_ertn [N];
  bit          m_csrwe[N];
  logic [CW-2:0] m_csrlo[N];
  logic [63:0] m_retired;

  // Cause table in priority order: excp bit position and its ecode.
  int          cause_bit [6] = '{0, 1, 5, 6, 7, 8};
  logic [5:0]  cause_code[6] = '{6'h00, 6'h08, 6'h0B, 6'h0C, 6'h0D, 6'h0E};

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_valid   = 1'b0;
    m_retired = 64'd0;
    for (int i = 0; i < N; i++) begin
      m_lv[i] = 0; m_res[i] = '0; m_pc[i] = '0; m_wen[i] = 0; m_widx[i] = '0;
      m_excp[i] = '0; m_ertn[i] = 0; m_csrwe[i] = 0; m_csrlo[i] = '0;
    end
  endtask

  // Clean packet: all lanes valid, random payload, no exceptions.
  task automatic drive_clean();
    logic [63:0] r;
    for (int i = 0; i < N; i++) begin
      r = {$urandom, $urandom};
      in_lane_v[i]          = 1'b1;
      in_result[i*DW +: DW] = $urandom;
      in_pc[i*DW +: DW]     = 32'h1c00_0000 + ($urandom_range(0, 1023) << 2);
      in_inst[i*DW +: DW]   = $urandom;
      in_wen[i]             = ($urandom_range(0, 3) != 0);
      in_widx[i*RW +: RW]   = RW'($urandom);
      in_excp[i*9 +: 9]     = 9'h000;
      in_ertn[i]            = 1'b0;
      in_csr[i*CW +: CW]    = r[CW-1:0];
    end
  endtask

  task automatic drive_rand();
    drive_clean();
    for (int i = 0; i < N; i++) begin
      in_lane_v[i] = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 5) == 0) in_excp[i*9 +: 9] = 9'($urandom) & 9'h1E3;
      in_ertn[i] = ($urandom_range(0, 9) == 0);
    end
  endtask

  // One cycle: inputs already driven at the falling edge; check outputs, advance model, clock.
  task automatic step();
    logic [8:0]    e [N];
    int            k;
    bit            is_exc, is_ertn, com;
    int            ncom;
    logic [N-1:0]  x_we, x_csr, o_csr;
    logic [5:0]    x_ecode;
    logic [DW-1:0] x_era, x_badv;
    bit            x_bv, lr;
    #1;
    for (int i = 0; i < N; i++) e[i] = m_excp[i];
`ifdef WB_SOFT_INT_EN
    if (m_valid && soft_int)
      for (int i = 0; i < N; i++) if (m_lv[i]) begin e[i][0] = 1'b1; break; end
`endif
    k = -1;
    if (m_valid)
      for (int i = 0; i < N; i++)
        if (k < 0 && m_lv[i] && (e[i] != 9'h0 || m_ertn[i])) k = i;
    is_exc = 0; is_ertn = 0;
    if (k >= 0) begin
      is_exc  = (e[k] != 9'h0);
      is_ertn = !is_exc;
    end
    ncom = is_ertn ? 1 : 0;
    for (int i = 0; i < N; i++) begin
      com     = m_valid && m_lv[i] && (k < 0 || i < k);
      x_we[i]  = com && m_wen[i];
      x_csr[i] = com && m_csrwe[i];
      o_csr[i] = csr_bus[i*CW + CW - 1];
      if (com) ncom++;
    end
    x_ecode = 6'h0; x_era = '0; x_badv = '0; x_bv = 0;
    if (is_exc) begin
      x_era = m_pc[k];
      for (int t = 0; t < 6; t++)
        if (e[k][cause_bit[t]]) begin
          x_ecode = cause_code[t];
          if (cause_bit[t] == 1) begin x_badv = m_pc[k]; x_bv = 1; end
          break;
        end
    end
    lr = !m_valid || right_ready;

    check_eq("left_ready",  {63'd0, left_ready},  {63'd0, lr});
    check_eq("right_valid", {63'd0, right_valid}, {63'd0, m_valid});
    check_eq("rf_we",       64'(rf_we),           64'(x_we));
    check_eq("csr_we",      64'(o_csr),           64'(x_csr));
    check_eq("excp_flush",  {63'd0, excp_flush},  {63'd0, is_exc});
    check_eq("ertn_flush",  {63'd0, ertn_flush},  {63'd0, is_ertn});
    check_eq("ecode",       64'(ecode),           64'(x_ecode));
    check_eq("esubcode",    64'(esubcode),        64'd0);
    check_eq("excp_era",    64'(excp_era),        64'(x_era));
    check_eq("badv",        64'(badv),            64'(x_badv));
    check_eq("badv_valid",  {63'd0, badv_valid},  {63'd0, x_bv});
    check_eq("retired",     retired,              m_retired);
    for (int i = 0; i < N; i++) begin
      check_eq("bypass_we", {63'd0, bypass[i*BW]}, {63'd0, x_we[i]});
      if (x_we[i]) begin
        check_eq("rf_wdata",  64'(rf_wdata[i*DW +: DW]), 64'(m_res[i]));
        check_eq("rf_waddr",  64'(rf_waddr[i*RW +: RW]), 64'(m_widx[i]));
        check_eq("byp_data",  64'(bypass[i*BW+RW+1 +: DW]), 64'(m_res[i]));
        check_eq("byp_idx",   64'(bypass[i*BW+1 +: RW]),  64'(m_widx[i]));
      end
      if (m_valid) check_eq("csr_lo", 64'(csr_bus[i*CW +: CW-1]), 64'(m_csrlo[i]));
    end

    if (reset) begin
      model_clear();
    end else begin
      if (m_valid && (right_ready || is_exc || is_ertn)) m_retired = m_retired + 64'(ncom);
      if (is_exc || is_ertn) begin
        m_valid = 0;
      end else if (left_valid && lr) begin
        m_valid = 1;
        for (int i = 0; i < N; i++) begin
          m_lv[i]    = in_lane_v[i];
          m_res[i]   = in_result[i*DW +: DW];
          m_pc[i]    = in_pc[i*DW +: DW];
          m_wen[i]   = in_wen[i];
          m_widx[i]  = in_widx[i*RW +: RW];
          m_excp[i]  = in_excp[i*9 +: 9];
          m_ertn[i]  = in_ertn[i];
          m_csrwe[i] = in_csr[i*CW + CW - 1];
          m_csrlo[i] = in_csr[i*CW +: CW-1];
        end
      end else if (right_ready) begin
        m_valid = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [63:0] saved;
    reset = 1'b1; left_valid = 1'b0; right_ready = 1'b1;
    drive_clean();
    repeat (3) @(posedge clk);
    @(negedge clk);
    model_clear();
    #1;
    check_eq("rst_left_ready",  {63'd0, left_ready},  64'd1);
    check_eq("rst_right_valid", {63'd0, right_valid}, 64'd0);
    check_eq("rst_rf_we",       64'(rf_we),           64'd0);
    check_eq("rst_retired",     retired,              64'd0);
    reset = 1'b0;

    // Four clean back-to-back packets, then drain.
    for (int p = 0; p < 4; p++) begin
      drive_clean(); in_wen = '1; left_valid = 1'b1; right_ready = 1'b1;
      step();
    end
    left_valid = 1'b0;
    step();
    check_eq("retired_4pk", retired, 64'd8);

    // Lane 1 syscall behind a clean lane 0.
    drive_clean(); in_wen = '1; left_valid = 1'b1;
    in_excp[9 +: 9] = 9'h020; in_pc[DW +: DW] = 32'h1c00_0004;
    step();
    left_valid = 1'b0; #1;
    check_eq("sys_flush", {63'd0, excp_flush}, 64'd1);
    check_eq("sys_ecode", 64'(ecode), 64'h0B);
    check_eq("sys_era",   64'(excp_era), 64'h1c00_0004);
    check_eq("sys_rf_we", 64'(rf_we), 64'b01);
    step();

    // Lane 0 address fault squashes both lanes.
    drive_clean(); in_wen = '1; left_valid = 1'b1;
    in_excp[0 +: 9] = 9'h002; in_pc[0 +: DW] = 32'h1c00_0102;
    step();
    left_valid = 1'b0; saved = m_retired; #1;
    check_eq("ade_ecode", 64'(ecode), 64'h08);
    check_eq("ade_badv",  64'(badv), 64'h1c00_0102);
    check_eq("ade_bv",    {63'd0, badv_valid}, 64'd1);
    check_eq("ade_rf_we", 64'(rf_we), 64'd0);
    step();
    check_eq("ade_retired", retired, saved);

    // Downstream stall for three cycles while full.
    drive_clean(); left_valid = 1'b1; right_ready = 1'b1;
    step();
    saved = m_retired; right_ready = 1'b0; drive_clean();
    repeat (3) step();
    check_eq("stall_retired", retired, saved);
    right_ready = 1'b1;
    step();
    check_eq("release_retired", retired, saved + 64'd2);
    left_valid = 1'b0;
    step();

    // Reset while a packet is held.
    drive_clean(); left_valid = 1'b1;
    step();
    reset = 1'b1; left_valid = 1'b0;
    step();
    reset = 1'b0; #1;
    check_eq("midrst_valid",   {63'd0, right_valid}, 64'd0);
    check_eq("midrst_retired", retired, 64'd0);

`ifdef WB_SOFT_INT_EN
    drive_clean(); in_wen = '1; left_valid = 1'b1;
    step();
    left_valid = 1'b0; soft_int = 1'b1; #1;
    check_eq("sint_flush", {63'd0, excp_flush}, 64'd1);
    check_eq("sint_ecode", 64'(ecode), 64'h00);
    check_eq("sint_era",   64'(excp_era), 64'(m_pc[0]));
    check_eq("sint_rf_we", 64'(rf_we), 64'd0);
    step();
    soft_int = 1'b0;
`endif

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      drive_rand();
      left_valid  = ($urandom_range(0, 3) != 0);
      right_ready = ($urandom_range(0, 3) != 0);
      reset       = ($urandom_range(0, 99) == 0);
`ifdef WB_SOFT_INT_EN
      soft_int    = ($urandom_range(0, 15) == 0);
`endif
      step();
    end
    reset = 1'b0; left_valid = 1'b0; right_ready = 1'b1;
`ifdef WB_SOFT_INT_EN
    soft_int = 1'b0;
`endif
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
